// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Shares one RAM port between the data-side request stream (coherence
// controller) and CPUS instruction-cache fetch ports. One requester is
// granted at a time and the grant lasts for exactly one word transfer.
// Data requests win by default, but after a completed data transfer a
// pending fetch goes first, so the two sides alternate under load.
// Fetch ports are served round-robin.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   dREN, dWEN          data read / write request
//   daddr, dstore       data address / write word
//   dwait, dload        data wait (low only in the completing cycle) / read word
//   iREN                per-core fetch request
//   iaddr               per-core fetch address, core k at [k*WORD_W +: WORD_W]
//   iwait, iload        per-core fetch wait / fetch word (same packing)
//   ramREN, ramWEN      RAM read / write enable
//   ramaddr, ramstore   RAM address / write word
//   ramload             RAM read word
//   ramstate            RAM state: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   ramerr              pulse in the cycle a granted transfer ends in ERROR

module ram_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     dREN,
    input  logic                     dWEN,
    input  logic [WORD_W-1:0]        daddr,
    input  logic [WORD_W-1:0]        dstore,
    output logic                     dwait,
    output logic [WORD_W-1:0]        dload,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic                     ramerr
);

    localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [OW:0] NCPU = CPUS[OW:0];

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr;
    logic            last_data;

    logic            dreq;
    logic            ireq;
    logic            done;
    logic [OW-1:0]   pick;
    logic            found;
    logic [OW:0]     sum;
    logic [OW-1:0]   idx;
    logic [OW-1:0]   rr_next;

    assign dreq = dREN | dWEN;
    assign ireq = |iREN;

    // A transfer finishes on the first ACCESS or ERROR seen while granted.
    assign done = (state != IDLE) &&
                  ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR));

    // Round-robin pick: first requesting core at or above rr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < CPUS; i++) begin
            sum = {1'b0, rr} + i[OW:0];
            if (sum >= NCPU) begin
                sum = sum - NCPU;
            end
            idx = sum[OW-1:0];
            if (!found && iREN[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign rr_next = ({1'b0, owner} == NCPU - 1'b1) ? '0 : owner + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            owner     <= '0;
            rr        <= '0;
            last_data <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && (!ireq || !last_data)) begin
                        state <= DGRANT;
                    end else if (ireq) begin
                        state <= IGRANT;
                        owner <= pick;
                    end
                end
                DGRANT: begin
                    if (done) begin
                        state     <= IDLE;
                        last_data <= 1'b1;
                    end else if (!dreq) begin
                        // Requester walked away: release without touching history.
                        state <= IDLE;
                    end
                end
                IGRANT: begin
                    if (done) begin
                        state     <= IDLE;
                        last_data <= 1'b0;
                        rr        <= rr_next;
                    end else if (!iREN[owner]) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Load words go straight through; they only matter when the wait is low.
    assign dload = ramload;
    assign iload = {CPUS{ramload}};

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = 1'b1;
        iwait    = '1;
        ramerr   = 1'b0;
        case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~done;
                ramerr   = (ramstate == RAM_ERROR);
            end
            IGRANT: begin
                ramREN        = 1'b1;
                ramaddr       = iaddr[owner*WORD_W +: WORD_W];
                iwait[owner]  = ~done;
                ramerr        = (ramstate == RAM_ERROR);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int CPUS   = 2;
    localparam int WORD_W = 32;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic                   dREN, dWEN;
    logic [WORD_W-1:0]      daddr, dstore;
    logic                   dwait;
    logic [WORD_W-1:0]      dload;
    logic [CPUS-1:0]        iREN;
    logic [CPUS*WORD_W-1:0] iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic                   ramREN, ramWEN;
    logic [WORD_W-1:0]      ramaddr, ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;
    logic                   ramerr;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.CPUS(CPUS), .WORD_W(WORD_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ramerr   (ramerr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ramREN"},   ramREN,   1'b0);
        check({tag, ".ramWEN"},   ramWEN,   1'b0);
        check({tag, ".ramaddr"},  ramaddr,  32'h0);
        check({tag, ".ramstore"}, ramstore, 32'h0);
        check({tag, ".dwait"},    dwait,    1'b1);
        check({tag, ".iwait"},    iwait,    2'b11);
        check({tag, ".ramerr"},   ramerr,   1'b0);
    endtask

    // Grant order expected with data and both fetch ports always requesting,
    // starting from reset: 0 = data, 1 = core 0, 2 = core 1.
    int          order [6] = '{0, 1, 0, 2, 0, 1};
    logic [31:0] gaddr [3] = '{32'h100, 32'h200, 32'h300};
    logic [1:0]  gwait [3] = '{2'b11, 2'b10, 2'b01};

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        iREN = 0; iaddr = 0; ramload = 0; ramstate = FREE;

        // Reset state
        tick(); tick();
        check_idle_outputs("reset");
        check("reset.rr",        dut.rr,        1'b0);
        check("reset.last_data", dut.last_data, 1'b0);
        RST = 1'b0;

        // Single fetch from core 0, two BUSY cycles then ACCESS
        iREN = 2'b01; iaddr[31:0] = 32'h40;
        #1;
        check("t1.idle.ramREN", ramREN, 1'b0);
        tick(); ramstate = BUSY; #1;
        check("t1.b1.ramREN",   ramREN,   1'b1);
        check("t1.b1.ramWEN",   ramWEN,   1'b0);
        check("t1.b1.ramaddr",  ramaddr,  32'h40);
        check("t1.b1.ramstore", ramstore, 32'h0);
        check("t1.b1.iwait",    iwait,    2'b11);
        check("t1.b1.dwait",    dwait,    1'b1);
        tick(); #1;
        check("t1.b2.ramREN",   ramREN,   1'b1);
        check("t1.b2.iwait",    iwait,    2'b11);
        tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        check("t1.ack.iwait",   iwait,        2'b10);
        check("t1.ack.iload0",  iload[31:0],  32'hDEADBEEF);
        check("t1.ack.ramerr",  ramerr,       1'b0);
        tick(); ramstate = FREE; iREN = 2'b00; #1;
        check("t1.after.ramREN",    ramREN,        1'b0);
        check("t1.after.iwait",     iwait,         2'b11);
        check("t1.after.rr",        dut.rr,        1'b1);
        check("t1.after.last_data", dut.last_data, 1'b0);

        // Data request with both enables: write wins
        dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
        tick(); ramstate = BUSY; #1;
        check("t2.b.ramWEN",   ramWEN,   1'b1);
        check("t2.b.ramREN",   ramREN,   1'b0);
        check("t2.b.ramaddr",  ramaddr,  32'h80);
        check("t2.b.ramstore", ramstore, 32'h12345678);
        check("t2.b.dwait",    dwait,    1'b1);
        tick(); ramstate = ACCESS; #1;
        check("t2.ack.dwait",  dwait,    1'b0);
        check("t2.ack.iwait",  iwait,    2'b11);
        tick(); ramstate = FREE; dREN = 0; dWEN = 0; #1;
        check("t2.after.ramWEN",    ramWEN,        1'b0);
        check("t2.after.last_data", dut.last_data, 1'b1);

        // Everyone requesting continuously: alternation plus round-robin
        RST = 1'b1; tick(); RST = 1'b0;
        dREN = 1; daddr = 32'h100; dstore = 32'h0;
        iREN = 2'b11; iaddr = {32'h300, 32'h200};
        for (int g = 0; g < 6; g++) begin
            tick(); ramstate = BUSY; #1;
            check($sformatf("t3.g%0d.ramREN", g),  ramREN,  1'b1);
            check($sformatf("t3.g%0d.ramWEN", g),  ramWEN,  1'b0);
            check($sformatf("t3.g%0d.ramaddr", g), ramaddr, {32'h0, gaddr[order[g]]});
            tick(); ramstate = ACCESS; ramload = 32'hA000 + g; #1;
            check($sformatf("t3.g%0d.dwait", g), dwait, (order[g] == 0) ? 1'b0 : 1'b1);
            check($sformatf("t3.g%0d.iwait", g), iwait, gwait[order[g]]);
            check($sformatf("t3.g%0d.load", g),
                  (order[g] == 2) ? iload[63:32] : dload, 32'hA000 + g);
            tick(); ramstate = FREE; #1;
            check($sformatf("t3.g%0d.idle", g), ramREN, 1'b0);
        end
        dREN = 0; iREN = 2'b00;

        // Both fetch ports from rr=0, then core 1 abandons its grant
        RST = 1'b1; tick(); RST = 1'b0;
        iREN = 2'b11;
        tick(); ramstate = BUSY; #1;
        check("t4.i0.ramaddr", ramaddr, 32'h200);
        tick(); ramstate = ACCESS; #1;
        check("t4.i0.iwait", iwait, 2'b10);
        tick(); ramstate = FREE; #1;
        check("t4.i0.rr", dut.rr, 1'b1);
        tick(); ramstate = BUSY; iREN = 2'b01; #1;
        check("t4.i1.ramaddr", ramaddr, 32'h300);
        check("t4.i1.iwait",   iwait,   2'b11);
        tick(); iREN = 2'b00; #1;
        check("t4.abandon.ramREN",    ramREN,        1'b0);
        check("t4.abandon.iwait",     iwait,         2'b11);
        check("t4.abandon.rr",        dut.rr,        1'b1);
        check("t4.abandon.last_data", dut.last_data, 1'b0);

        // ERROR completing a data read
        ramstate = FREE; dREN = 1; daddr = 32'h44;
        tick(); ramstate = BUSY; #1;
        check("t5.b.ramREN",  ramREN,  1'b1);
        check("t5.b.ramWEN",  ramWEN,  1'b0);
        check("t5.b.ramaddr", ramaddr, 32'h44);
        check("t5.b.ramerr",  ramerr,  1'b0);
        tick(); ramstate = ERROR; #1;
        check("t5.err.dwait",  dwait,  1'b0);
        check("t5.err.ramerr", ramerr, 1'b1);
        tick(); ramstate = FREE; dREN = 0; #1;
        check("t5.after.ramerr",    ramerr,        1'b0);
        check("t5.after.dwait",     dwait,         1'b1);
        check("t5.after.ramREN",    ramREN,        1'b0);
        check("t5.after.last_data", dut.last_data, 1'b1);

        // Reset during a BUSY fetch grant
        iREN = 2'b01; iaddr[31:0] = 32'h40;
        tick(); ramstate = BUSY; #1;
        check("t6.b.ramREN",  ramREN,  1'b1);
        check("t6.b.ramaddr", ramaddr, 32'h40);
        RST = 1'b1;
        tick();
        check_idle_outputs("t6.rst");
        check("t6.rst.rr",        dut.rr,        1'b0);
        check("t6.rst.last_data", dut.last_data, 1'b0);
        RST = 1'b0; iREN = 2'b00; ramstate = FREE;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
